lu_sched: RTL

Job controller and row-memory arbiter for the `lu` decomposition engine. Sequences one factorisation per job:
- host loads SIZE complex rows into a shared single-port row RAM;
- host requests start; the block pulses the engine's `start`;
- the engine's row reads and write-backs are served from the same RAM until the engine goes idle;
- the block then signals done.

It sits between the host/DMA side, the row RAM macro and `lu`.

---
 rtl/lu_sched.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/lu_sched.sv
// lu_sched: job controller and single-port row-RAM arbiter for the lu engine.
// The host loads rows while idle; the engine owns the RAM while a job runs.
module lu_sched #(
   parameter int unsigned SIZE    = 32,
   parameter int unsigned WIDTH   = 64,
   parameter int unsigned TIMEOUT = 15,
   localparam int unsigned ROW_W  = SIZE * 2 * WIDTH,
   localparam int unsigned AW     = $clog2(SIZE)
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             host_wr_valid_i,
   output logic             host_wr_ready_o,
   input  logic [AW-1:0]    host_wr_addr_i,
   input  logic [ROW_W-1:0] host_wr_row_i,
   input  logic             host_start_i,
   input  logic             host_abort_i,
   output logic             host_busy_o,
   output logic             host_done_o,
   output logic             err_o,
   output logic [31:0]      run_cycles_o,
   output logic             lu_start_o,
   output logic             lu_flush_o,
   input  logic             lu_busy_i,
   input  logic             lu_in_ready_i,
   input  logic             lu_rd_valid_i,
   input  logic [AW-1:0]    lu_rd_addr_i,
   output logic             lu_rd_valid_o,
   output logic [AW-1:0]    lu_rd_addr_o,
   output logic [ROW_W-1:0] lu_rd_row_o,
   input  logic             lu_wr_valid_i,
   input  logic [AW-1:0]    lu_wr_addr_i,
   input  logic [ROW_W-1:0] lu_wr_row_i,
   output logic             lu_wr_ready_o,
   output logic             ram_en_o,
   output logic             ram_we_o,
   output logic [AW-1:0]    ram_addr_o,
   output logic [ROW_W-1:0] ram_wdata_o,
   input  logic [ROW_W-1:0] ram_rdata_i
);

   localparam int unsigned CNT_W = $clog2(SIZE + 1);
   localparam int unsigned TO_W  = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_KICK      = 3'd1,
      S_WAIT_BUSY = 3'd2,
      S_RUN       = 3'd3,
      S_DONE      = 3'd4
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] rows_q;
   logic [TO_W-1:0]  to_q;
   logic [31:0]      run_q;
   logic             wr_ready_q, busy_q, done_q, err_q, start_q, flush_q;
   logic             rd_valid_q;
   logic [AW-1:0]    rd_addr_q;

   logic eng_own, host_acc, start_acc, abort_acc, timeout, run_exit, eng_rd, eng_wr;

   assign eng_own   = (state_q == S_WAIT_BUSY) || (state_q == S_RUN);
   assign host_acc  = host_wr_valid_i && wr_ready_q;
   assign start_acc = (state_q == S_IDLE) && host_start_i && (rows_q == CNT_W'(SIZE));
   assign abort_acc = host_abort_i &&
                      ((state_q == S_KICK) || (state_q == S_WAIT_BUSY) || (state_q == S_RUN));
   assign timeout   = (state_q == S_WAIT_BUSY) && !lu_busy_i && (to_q == TO_W'(TIMEOUT - 1));
   assign run_exit  = (state_q == S_RUN) && !lu_busy_i && lu_in_ready_i;
   assign eng_rd    = eng_own && lu_rd_valid_i;
   assign eng_wr    = eng_own && lu_wr_valid_i && !lu_rd_valid_i;

   // State register
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) state_q <= S_IDLE;
      else         state_q <= state_d;
   end

   // Next-state logic; abort overrides every other exit
   always_comb begin
      state_d = state_q;
      if (abort_acc) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE:      if (start_acc) state_d = S_KICK;
            S_KICK:      state_d = S_WAIT_BUSY;
            S_WAIT_BUSY: begin
               if (lu_busy_i)    state_d = S_RUN;
               else if (timeout) state_d = S_IDLE;
            end
            S_RUN:       if (run_exit) state_d = S_DONE;
            S_DONE:      state_d = S_IDLE;
            default:     state_d = S_IDLE;
         endcase
      end
   end

   // RAM arbitration: engine read, then engine write, then host write
   always_comb begin
      lu_wr_ready_o = eng_own && !lu_rd_valid_i;
      ram_en_o      = 1'b0;
      ram_we_o      = 1'b0;
      ram_addr_o    = '0;
      ram_wdata_o   = '0;
      if (eng_rd) begin
         ram_en_o   = 1'b1;
         ram_addr_o = lu_rd_addr_i;
      end else if (eng_wr) begin
         ram_en_o    = 1'b1;
         ram_we_o    = 1'b1;
         ram_addr_o  = lu_wr_addr_i;
         ram_wdata_o = lu_wr_row_i;
      end else if (host_acc) begin
         ram_en_o    = 1'b1;
         ram_we_o    = 1'b1;
         ram_addr_o  = host_wr_addr_i;
         ram_wdata_o = host_wr_row_i;
      end
   end

   // Registered status, counters and read-response tracking
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ready_q <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         start_q    <= 1'b0;
         flush_q    <= 1'b0;
         rd_valid_q <= 1'b0;
         rd_addr_q  <= '0;
         rows_q     <= '0;
         to_q       <= '0;
         run_q      <= '0;
      end else begin
         wr_ready_q <= (state_d == S_IDLE);
         busy_q     <= (state_d != S_IDLE);
         done_q     <= (state_d == S_DONE);
         start_q    <= (state_d == S_KICK);
         flush_q    <= abort_acc;
         rd_valid_q <= eng_rd && !abort_acc;
         if (eng_rd) rd_addr_q <= lu_rd_addr_i;

         if (start_acc)                                rows_q <= '0;
         else if (host_acc && rows_q != CNT_W'(SIZE))  rows_q <= rows_q + CNT_W'(1);

         if (state_q == S_WAIT_BUSY) to_q <= to_q + TO_W'(1);
         else                        to_q <= '0;

         if (start_acc)                    err_q <= 1'b0;
         else if (timeout && !abort_acc)   err_q <= 1'b1;

         if (start_acc)                             run_q <= '0;
         else if (state_q == S_RUN && run_q != '1)  run_q <= run_q + 32'd1;
      end
   end

   assign host_wr_ready_o = wr_ready_q;
   assign host_busy_o     = busy_q;
   assign host_done_o     = done_q;
   assign err_o           = err_q;
   assign run_cycles_o    = run_q;
   assign lu_start_o      = start_q;
   assign lu_flush_o      = flush_q;
   assign lu_rd_valid_o   = rd_valid_q;
   assign lu_rd_addr_o    = rd_addr_q;
   assign lu_rd_row_o     = rd_valid_q ? ram_rdata_i : '0;

endmodule
